// File: rtl/ffe_coef_ctrl.sv
// FFE coefficient controller: host shadow bank, strobe-aligned swap into the active bank, flush wait.
// Define FFE_COEF_LMS_EN to enable saturating LMS updates of the active bank while idle.
module ffe_coef_ctrl #(
   parameter int COEF_BW   = 9,
   parameter int N_COEF    = 7,
   parameter int ADDR_BW   = 3,
   parameter int DELTA_BW  = 5,
   parameter int MAIN_TAP  = 3,
   parameter int MAIN_VAL  = 128,
   parameter int FLUSH_LEN = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_en,
   input  logic                        i_wr_valid,
   input  logic [ADDR_BW-1:0]          i_wr_addr,
   input  logic [COEF_BW-1:0]          i_wr_data,
   output logic                        o_wr_ready,
   output logic                        o_wr_err,
   input  logic                        i_commit,
   output logic                        o_busy,
   output logic                        o_done,
   input  logic                        i_adapt,
   input  logic                        i_upd_valid,
   input  logic [DELTA_BW*N_COEF-1:0]  i_upd_delta,
   output logic [COEF_BW*N_COEF-1:0]   o_coefs
);

   typedef enum logic [1:0] {IDLE, WAIT_EN, FLUSH} state_t;

   localparam logic [COEF_BW-1:0] RST_MAIN = COEF_BW'(MAIN_VAL);

   state_t             state;
   logic [7:0]         flush_cnt;
   logic [COEF_BW-1:0] shadow [N_COEF];
   logic [COEF_BW-1:0] active [N_COEF];
   logic               wr_acc;
   logic               addr_ok;

   assign wr_acc  = i_wr_valid & o_wr_ready;
   assign addr_ok = {{(32-ADDR_BW){1'b0}}, i_wr_addr} < 32'(N_COEF);

`ifdef FFE_COEF_LMS_EN
   // Add in COEF_BW+1 bits; a disagreement between the top two bits means overflow.
   function automatic logic [COEF_BW-1:0] sat_add(input logic [COEF_BW-1:0] c,
                                                  input logic [DELTA_BW-1:0] d);
      logic [COEF_BW:0] s;
      s = {c[COEF_BW-1], c} + {{(COEF_BW+1-DELTA_BW){d[DELTA_BW-1]}}, d};
      if (s[COEF_BW] != s[COEF_BW-1])
         sat_add = s[COEF_BW] ? {1'b1, {(COEF_BW-1){1'b0}}} : {1'b0, {(COEF_BW-1){1'b1}}};
      else
         sat_add = s[COEF_BW-1:0];
   endfunction
`else
   logic unused_lms;
   assign unused_lms = ^{i_adapt, i_upd_valid, i_upd_delta};
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         flush_cnt  <= '0;
         o_wr_ready <= 1'b1;
         o_wr_err   <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         for (int unsigned k = 0; k < N_COEF; k++) begin
            shadow[k] <= (k == MAIN_TAP) ? RST_MAIN : '0;
            active[k] <= (k == MAIN_TAP) ? RST_MAIN : '0;
         end
      end else begin
         o_done   <= 1'b0;
         o_wr_err <= wr_acc & ~addr_ok;
         if (wr_acc && addr_ok) begin
            for (int unsigned k = 0; k < N_COEF; k++)
               if (ADDR_BW'(k) == i_wr_addr) shadow[k] <= i_wr_data;
         end
         case (state)
            IDLE: begin
`ifdef FFE_COEF_LMS_EN
               if (i_adapt && i_upd_valid) begin
                  for (int unsigned k = 0; k < N_COEF; k++)
                     active[k] <= sat_add(active[k], i_upd_delta[k*DELTA_BW +: DELTA_BW]);
               end
`endif
               if (i_commit) begin
                  state      <= WAIT_EN;
                  o_wr_ready <= 1'b0;
                  o_busy     <= 1'b1;
               end
            end
            WAIT_EN: begin
               // Swap only on a strobe so the filter sees a whole tap set.
               if (i_en) begin
                  for (int unsigned k = 0; k < N_COEF; k++) active[k] <= shadow[k];
                  flush_cnt <= 8'(FLUSH_LEN);
                  state     <= FLUSH;
               end
            end
            FLUSH: begin
               if (i_en) begin
                  if (flush_cnt == 8'd1) begin
                     flush_cnt  <= '0;
                     o_done     <= 1'b1;
                     o_busy     <= 1'b0;
                     o_wr_ready <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     flush_cnt <= flush_cnt - 8'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      o_coefs = '0;
      for (int unsigned k = 0; k < N_COEF; k++)
         o_coefs[k*COEF_BW +: COEF_BW] = active[k];
   end

endmodule

// File: tb/tb_ffe_coef_ctrl.sv
// Directed self-checking bench for ffe_coef_ctrl (default parameters).
module tb_ffe_coef_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        wr_valid;
   logic [2:0]  wr_addr;
   logic [8:0]  wr_data;
   logic        wr_ready;
   logic        wr_err;
   logic        commit;
   logic        busy;
   logic        done;
   logic        adapt;
   logic        upd_valid;
   logic [34:0] upd_delta;
   logic [62:0] coefs;

   int nerr = 0;
   int nchk = 0;

   ffe_coef_ctrl #(
      .COEF_BW(9), .N_COEF(7), .ADDR_BW(3), .DELTA_BW(5),
      .MAIN_TAP(3), .MAIN_VAL(128), .FLUSH_LEN(8)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_en(en),
      .i_wr_valid(wr_valid), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .o_wr_ready(wr_ready), .o_wr_err(wr_err),
      .i_commit(commit), .o_busy(busy), .o_done(done),
      .i_adapt(adapt), .i_upd_valid(upd_valid), .i_upd_delta(upd_delta),
      .o_coefs(coefs)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [62:0] pack(input int t0, input int t1, input int t2, input int t3,
                                        input int t4, input int t5, input int t6);
      pack = {9'(t6), 9'(t5), 9'(t4), 9'(t3), 9'(t2), 9'(t1), 9'(t0)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic swap_strobe();
      tick(); tick(); tick();
      en = 1'b1; tick(); en = 1'b0;
   endtask

   task automatic flush8();
      for (int i = 1; i <= 8; i++) begin
         tick(); tick(); tick();
         en = 1'b1; tick(); en = 1'b0;
         if (i == 7) chk("done_early", {63'd0, done}, 64'd0);
         if (i == 8) begin
            chk("done_pulse", {63'd0, done}, 64'd1);
            chk("busy_after_flush", {63'd0, busy}, 64'd0);
            chk("ready_after_flush", {63'd0, wr_ready}, 64'd1);
         end
      end
      tick();
      chk("done_one_cycle", {63'd0, done}, 64'd0);
   endtask

   localparam logic [62:0] RST_COEFS = 63'h0000_0004_0000_0000;
   localparam logic [62:0] NEW_COEFS = 63'h0440_0004_0000_01FB;

   initial begin
      rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      commit = 1'b0; adapt = 1'b0; upd_valid = 1'b0; upd_delta = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_coefs", {1'b0, coefs}, {1'b0, RST_COEFS});
      chk("rst_coefs_pack", {1'b0, coefs}, {1'b0, pack(0, 0, 0, 128, 0, 0, 0)});
      chk("rst_ready", {63'd0, wr_ready}, 64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_err", {63'd0, wr_err}, 64'd0);

      // Shadow writes, then commit with i_en every 4 clocks.
      wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 9'h1FB; tick();
      wr_addr = 3'd6; wr_data = 9'd17; tick();
      wr_valid = 1'b0;
      chk("valid_wr_no_err", {63'd0, wr_err}, 64'd0);
      chk("active_untouched", {1'b0, coefs}, {1'b0, RST_COEFS});
      commit = 1'b1; tick(); commit = 1'b0;
      chk("busy_wait", {63'd0, busy}, 64'd1);
      chk("ready_wait", {63'd0, wr_ready}, 64'd0);
      tick(); tick(); tick();
      chk("coefs_before_swap", {1'b0, coefs}, {1'b0, RST_COEFS});
      en = 1'b1; tick(); en = 1'b0;
      chk("coefs_after_swap", {1'b0, coefs}, {1'b0, NEW_COEFS});
      chk("busy_flush", {63'd0, busy}, 64'd1);
      flush8();

      // Out-of-range write.
      wr_valid = 1'b1; wr_addr = 3'd7; wr_data = 9'h055; tick();
      wr_valid = 1'b0;
      chk("err_pulse", {63'd0, wr_err}, 64'd1);
      tick();
      chk("err_one_cycle", {63'd0, wr_err}, 64'd0);
      chk("err_active_same", {1'b0, coefs}, {1'b0, NEW_COEFS});

      // Commit stalled without strobes; writes and a second commit are ignored.
      commit = 1'b1; tick(); commit = 1'b0;
      wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 9'd99;
      for (int i = 0; i < 50; i++) begin
         if (i == 5) wr_valid = 1'b0;
         commit = (i == 20);
         tick();
      end
      commit = 1'b0;
      chk("stall_busy", {63'd0, busy}, 64'd1);
      chk("stall_ready", {63'd0, wr_ready}, 64'd0);
      chk("stall_coefs", {1'b0, coefs}, {1'b0, NEW_COEFS});
      en = 1'b1; tick(); en = 1'b0;
      chk("stall_swap_shadow", {1'b0, coefs}, {1'b0, NEW_COEFS});
      flush8();
      tick(); tick();
      chk("no_queued_commit", {63'd0, busy}, 64'd0);

      // Load tap0=-250, tap3=250.
      wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 9'h106; tick();
      wr_addr = 3'd3; wr_data = 9'd250; tick();
      wr_valid = 1'b0;
      commit = 1'b1; tick(); commit = 1'b0;
      en = 1'b1; tick(); en = 1'b0;
      chk("big_taps_swap", {1'b0, coefs}, {1'b0, pack(-250, 0, 0, 250, 0, 0, 17)});
      flush8();

      upd_delta = '0;
      upd_delta[4:0]   = 5'h10;
      upd_delta[19:15] = 5'd10;
      adapt = 1'b1; upd_valid = 1'b1; tick(); upd_valid = 1'b0;
`ifdef FFE_COEF_LMS_EN
      chk("lms_saturate", {1'b0, coefs}, {1'b0, pack(-256, 0, 0, 255, 0, 0, 17)});
      commit = 1'b1; tick(); commit = 1'b0;
      en = 1'b1; tick(); en = 1'b0;
      chk("lms_shadow_intact", {1'b0, coefs}, {1'b0, pack(-250, 0, 0, 250, 0, 0, 17)});
      tick();
      upd_valid = 1'b1; tick(); upd_valid = 1'b0;
      chk("lms_frozen_flush", {1'b0, coefs}, {1'b0, pack(-250, 0, 0, 250, 0, 0, 17)});
      flush8();
`else
      chk("lms_ignored", {1'b0, coefs}, {1'b0, pack(-250, 0, 0, 250, 0, 0, 17)});
`endif
      adapt = 1'b0;

      // Reset in the middle of a commit.
      wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 9'd33; tick();
      wr_valid = 1'b0;
      commit = 1'b1; tick(); commit = 1'b0;
      en = 1'b1; tick(); en = 1'b0;
      chk("pre_rst_swap", {1'b0, coefs}, {1'b0, pack(-250, 0, 0, 250, 0, 33, 17)});
      rst = 1'b1; tick(); rst = 1'b0;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_ready", {63'd0, wr_ready}, 64'd1);
      chk("midrst_coefs", {1'b0, coefs}, {1'b0, RST_COEFS});
      for (int i = 0; i < 10; i++) begin
         en = 1'b1; tick(); en = 1'b0;
         chk("midrst_no_done", {63'd0, done}, 64'd0);
         tick();
      end
      commit = 1'b1; tick(); commit = 1'b0;
      swap_strobe();
      chk("midrst_shadow_reset", {1'b0, coefs}, {1'b0, RST_COEFS});
      flush8();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
